id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register_pkg.sv | 45 ++++
 rtl/id_ex_register_if.sv | 49 ++++
 rtl/id_ex_register_load_use_detector.sv | 22 ++
 rtl/id_ex_register.sv | 124 ++++++++++++
 tb/tb_id_ex_register.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_register_pkg.sv
// Shared types for the ID/EX pipeline latch: word and register-address types,
// the latched bundle struct, latch state encoding and the operand select helper.
package id_ex_register_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef struct packed {
    word_t     pc;
    word_t     imm;
    word_t     op1;
    word_t     op2;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rd_we;
    logic      is_load;
  } id_ex_bundle_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } id_ex_state_t;

  // x0 always reads as zero; otherwise take the writeback value when the
  // bypass is enabled and the writeback targets the same register.
  function automatic word_t pick_operand(
    input reg_addr_t rs,
    input word_t     rf_data,
    input logic      wb_we,
    input reg_addr_t wb_addr,
    input word_t     wb_data,
    input logic      bypass_en
  );
    word_t op;
    op = rf_data;
    if (rs == '0) begin
      op = '0;
    end else if (bypass_en && wb_we && (wb_addr == rs)) begin
      op = wb_data;
    end
    return op;
  endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX latch.
// slave: the latch itself; master: whoever drives decode and consumes execute.
interface id_ex_register_if
  import id_ex_register_pkg::*;
#(
  parameter int CTRL_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  word_t             in_pc;
  word_t             in_imm;
  reg_addr_t         in_rs1;
  reg_addr_t         in_rs2;
  reg_addr_t         in_rd;
  logic              in_rd_we;
  logic              in_is_load;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  word_t             out_pc;
  word_t             out_imm;
  word_t             out_op1;
  word_t             out_op2;
  reg_addr_t         out_rs1;
  reg_addr_t         out_rs2;
  reg_addr_t         out_rd;
  logic              out_rd_we;
  logic              out_is_load;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_we, in_is_load, in_ctrl,
    output in_ready,
    output out_valid, out_pc, out_imm, out_op1, out_op2, out_rs1, out_rs2, out_rd,
           out_rd_we, out_is_load, out_ctrl,
    input  out_ready
  );

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_we, in_is_load, in_ctrl,
    input  in_ready,
    input  out_valid, out_pc, out_imm, out_op1, out_op2, out_rs1, out_rs2, out_rd,
           out_rd_we, out_is_load, out_ctrl,
    output out_ready
  );

endinterface

// File: rtl/id_ex_register_load_use_detector.sv
// Load-use hazard check: a latched load writing a nonzero rd that the
// incoming instruction reads must not be paired with it in execute.
module load_use_detector
  import id_ex_register_pkg::*;
(
  input  logic      full,
  input  logic      in_valid,
  input  logic      lat_is_load,
  input  logic      lat_rd_we,
  input  reg_addr_t lat_rd,
  input  reg_addr_t in_rs1,
  input  reg_addr_t in_rs2,
  output logic      hazard
);

  // Purely combinational compare of latched destination vs incoming sources.
  always_comb begin
    hazard = in_valid && full && lat_is_load && lat_rd_we && (lat_rd != '0) &&
             ((lat_rd == in_rs1) || (lat_rd == in_rs2));
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX single-entry pipeline latch with load-use stall and flush.
// Optional build macro ID_EX_WB_BYPASS_EN: operands captured on accept take the
// writeback port value when it targets the source register in the same cycle.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int CTRL_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  id_ex_register_if.slave     bus,
  output reg_addr_t           rf_addr1,
  output reg_addr_t           rf_addr2,
  input  word_t               rf_data1,
  input  word_t               rf_data2,
  input  logic                wb_we,
  input  reg_addr_t           wb_addr,
  input  word_t               wb_data,
  input  logic                flush,
  output logic [31:0]         stall_count
);

`ifdef ID_EX_WB_BYPASS_EN
  localparam logic WB_BYPASS_EN = 1'b1;
`else
  localparam logic WB_BYPASS_EN = 1'b0;
`endif

  id_ex_state_t      state_q, state_d;
  id_ex_bundle_t     bundle_q, bundle_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic hazard;
  logic full;
  logic in_ready;
  logic accept;
  logic fire;

  assign full = (state_q == ST_FULL);

  load_use_detector u_load_use_detector (
    .full        (full),
    .in_valid    (bus.in_valid),
    .lat_is_load (bundle_q.is_load),
    .lat_rd_we   (bundle_q.rd_we),
    .lat_rd      (bundle_q.rd),
    .in_rs1      (bus.in_rs1),
    .in_rs2      (bus.in_rs2),
    .hazard      (hazard)
  );

  // Handshake: reset and flush both block the decode side outright.
  always_comb begin
    in_ready = !reset && !hazard && !flush && (!full || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    fire     = full && bus.out_ready;
  end

  // Next-state: reset > flush > accept > downstream fire > hold.
  always_comb begin
    state_d       = state_q;
    bundle_d      = bundle_q;
    ctrl_d        = ctrl_q;
    stall_count_d = stall_count_q;
    if (reset) begin
      state_d       = ST_EMPTY;
      bundle_d      = '0;
      ctrl_d        = '0;
      stall_count_d = '0;
    end else if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      if (hazard) begin
        stall_count_d = stall_count_q + 32'd1;
      end
      if (accept) begin
        state_d          = ST_FULL;
        bundle_d.pc      = bus.in_pc;
        bundle_d.imm     = bus.in_imm;
        bundle_d.rs1     = bus.in_rs1;
        bundle_d.rs2     = bus.in_rs2;
        bundle_d.rd      = bus.in_rd;
        bundle_d.rd_we   = bus.in_rd_we;
        bundle_d.is_load = bus.in_is_load;
        bundle_d.op1     = pick_operand(bus.in_rs1, rf_data1, wb_we, wb_addr, wb_data,
                                        WB_BYPASS_EN);
        bundle_d.op2     = pick_operand(bus.in_rs2, rf_data2, wb_we, wb_addr, wb_data,
                                        WB_BYPASS_EN);
        ctrl_d           = bus.in_ctrl;
      end else if (fire) begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State registers; reset is applied through the _d path (synchronous).
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    bundle_q      <= bundle_d;
    ctrl_q        <= ctrl_d;
    stall_count_q <= stall_count_d;
  end

  // Registered outputs and combinational register-file addresses.
  always_comb begin
    bus.in_ready    = in_ready;
    bus.out_valid   = full;
    bus.out_pc      = bundle_q.pc;
    bus.out_imm     = bundle_q.imm;
    bus.out_op1     = bundle_q.op1;
    bus.out_op2     = bundle_q.op2;
    bus.out_rs1     = bundle_q.rs1;
    bus.out_rs2     = bundle_q.rs2;
    bus.out_rd      = bundle_q.rd;
    bus.out_rd_we   = bundle_q.rd_we;
    bus.out_is_load = bundle_q.is_load;
    bus.out_ctrl    = ctrl_q;
    rf_addr1        = bus.in_rs1;
    rf_addr2        = bus.in_rs2;
    stall_count     = stall_count_q;
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: stimulus pushes expected latched bundles
// into a scoreboard queue; a monitor pops and compares on every downstream fire.
module tb_id_ex_register;
  import id_ex_register_pkg::*;

  localparam int CTRL_W = 8;

  typedef struct packed {
    id_ex_bundle_t     b;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  logic        clk;
  logic        reset;
  reg_addr_t   rf_addr1, rf_addr2;
  word_t       rf_data1, rf_data2;
  logic        wb_we;
  reg_addr_t   wb_addr;
  word_t       wb_data;
  logic        flush;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  id_ex_register_if #(.CTRL_W(CTRL_W)) bus ();

  id_ex_register #(.CTRL_W(CTRL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .rf_addr1    (rf_addr1),
    .rf_addr2    (rf_addr2),
    .rf_data1    (rf_data1),
    .rf_data2    (rf_data2),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input word_t pc, input word_t imm, input reg_addr_t rs1,
                       input reg_addr_t rs2, input reg_addr_t rd, input logic rd_we,
                       input logic is_load, input logic [CTRL_W-1:0] ctrl,
                       input word_t d1, input word_t d2);
    bus.in_valid   = 1'b1;
    bus.in_pc      = pc;
    bus.in_imm     = imm;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.in_rd_we   = rd_we;
    bus.in_is_load = is_load;
    bus.in_ctrl    = ctrl;
    rf_data1       = d1;
    rf_data2       = d2;
  endtask

  function automatic exp_t mk(input word_t pc, input word_t imm, input word_t op1,
                              input word_t op2, input reg_addr_t rs1, input reg_addr_t rs2,
                              input reg_addr_t rd, input logic rd_we, input logic is_load,
                              input logic [CTRL_W-1:0] ctrl);
    exp_t e;
    e.b.pc = pc; e.b.imm = imm; e.b.op1 = op1; e.b.op2 = op2;
    e.b.rs1 = rs1; e.b.rs2 = rs2; e.b.rd = rd; e.b.rd_we = rd_we; e.b.is_load = is_load;
    e.ctrl = ctrl;
    return e;
  endfunction

  // Monitor: a transfer happens at the coming edge when FULL and out_ready.
  always @(negedge clk) begin
    if (reset === 1'b0 && flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t act;
      act = mk(bus.out_pc, bus.out_imm, bus.out_op1, bus.out_op2, bus.out_rs1, bus.out_rs2,
               bus.out_rd, bus.out_rd_we, bus.out_is_load, bus.out_ctrl);
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected pc=%h op1=%h op2=%h", act.b.pc, act.b.op1, act.b.op2);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL sb_bundle actual pc=%h imm=%h op1=%h op2=%h rs=%0d/%0d rd=%0d we=%b ld=%b ctrl=%h required pc=%h imm=%h op1=%h op2=%h rs=%0d/%0d rd=%0d we=%b ld=%b ctrl=%h",
                   act.b.pc, act.b.imm, act.b.op1, act.b.op2, act.b.rs1, act.b.rs2, act.b.rd,
                   act.b.rd_we, act.b.is_load, act.ctrl,
                   e.b.pc, e.b.imm, e.b.op1, e.b.op2, e.b.rs1, e.b.rs2, e.b.rd,
                   e.b.rd_we, e.b.is_load, e.ctrl);
        end
      end
    end
  end

  word_t exp_bypass_op1;

  initial begin
`ifdef ID_EX_WB_BYPASS_EN
    exp_bypass_op1 = 32'h99;
`else
    exp_bypass_op1 = 32'h10;
`endif
    reset = 1'b1; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    bus.out_ready = 1'b0;
    drive(32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 8'h00, 32'h1, 32'h2);
    step();
    chk("in_ready_during_reset", {31'b0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b0; bus.in_valid = 1'b0;
    #2;
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_stall_count", stall_count, 32'd0);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    chk("reset_out_ctrl", {24'b0, bus.out_ctrl}, 32'd0);

    // Basic accept: rs2 = x0 forces op2 to zero regardless of rf_data2.
    step();
    drive(32'h100, 32'h4, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 8'hA5, 32'h11, 32'h55);
    #2;
    chk("rf_addr1", {27'b0, rf_addr1}, 32'd5);
    chk("rf_addr2", {27'b0, rf_addr2}, 32'd0);
    chk("in_ready_empty", {31'b0, bus.in_ready}, 32'd1);
    sb_q.push_back(mk(32'h100, 32'h4, 32'h11, 32'h0, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 8'hA5));
    step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("accept_op1", bus.out_op1, 32'h11);
    chk("accept_op2", bus.out_op2, 32'h0);
    step();
    bus.out_ready = 1'b0;
    #2;
    chk("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: same source register on both ports, then 3 stalled cycles.
    drive(32'h200, 32'h8, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 8'h3C, 32'h77, 32'h77);
    sb_q.push_back(mk(32'h200, 32'h8, 32'h77, 32'h77, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 8'h3C));
    step();
    drive(32'h204, 32'hC, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 8'h5A, 32'h22, 32'h33);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_out_pc_hold", bus.out_pc, 32'h200);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sb_q.push_back(mk(32'h204, 32'hC, 32'h22, 32'h33, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 8'h5A));
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;

    // Load to x0 never creates a hazard.
    drive(32'h400, 32'h0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 8'h01, 32'h60, 32'h0);
    sb_q.push_back(mk(32'h400, 32'h0, 32'h60, 32'h0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 8'h01));
    step();
    drive(32'h404, 32'h1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 8'h02, 32'hDEAD, 32'hBEEF);
    bus.out_ready = 1'b1;
    #1;
    chk("rd0_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sb_q.push_back(mk(32'h404, 32'h1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 8'h02));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("rd0_stall_count", stall_count, 32'd0);
    step();
    bus.out_ready = 1'b0;

    // Load-use: exactly one bubble, then the dependent instruction enters.
    drive(32'h300, 32'h10, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 8'h10, 32'h5, 32'h0);
    sb_q.push_back(mk(32'h300, 32'h10, 32'h5, 32'h0, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 8'h10));
    step();
    drive(32'h304, 32'h14, 5'd4, 5'd7, 5'd9, 1'b1, 1'b0, 8'h20, 32'h44, 32'h70);
    bus.out_ready = 1'b1;
    #1;
    chk("lu_in_ready_hazard", {31'b0, bus.in_ready}, 32'd0);
    step();
    #1;
    chk("lu_bubble_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("lu_stall_count", stall_count, 32'd1);
    chk("lu_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
    sb_q.push_back(mk(32'h304, 32'h14, 32'h44, 32'h70, 5'd4, 5'd7, 5'd9, 1'b1, 1'b0, 8'h20));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("lu_dep_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("lu_stall_count_hold", stall_count, 32'd1);
    step();
    bus.out_ready = 1'b0;

    // Flush kills the latched load and the incoming dependent; no stall counted.
    drive(32'h500, 32'h0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 8'h30, 32'h1, 32'h2);
    step();
    #1;
    chk("fl_out_pc", bus.out_pc, 32'h500);
    drive(32'h504, 32'h0, 5'd7, 5'd3, 5'd5, 1'b1, 1'b0, 8'h31, 32'h7, 32'h3);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, bus.in_ready}, 32'd0);
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("fl_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_out_pc_hold", bus.out_pc, 32'h500);
    chk("fl_stall_count", stall_count, 32'd1);

    // Reset in the middle of a load-use stall.
    drive(32'h600, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 8'h40, 32'h1, 32'h2);
    step();
    drive(32'h604, 32'h0, 5'd8, 5'd0, 5'd5, 1'b1, 1'b0, 8'h41, 32'h8, 32'h0);
    step();
    step();
    #1;
    chk("rs_stall_count_pre", stall_count, 32'd3);
    reset = 1'b1;
    #1;
    chk("rs_in_ready", {31'b0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("rs_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rs_stall_count", stall_count, 32'd0);
    chk("rs_out_rd", {27'b0, bus.out_rd}, 32'd0);

    // Writeback bypass (or plain rf_data when the bypass is not built in).
    drive(32'h700, 32'h0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 8'h50, 32'h10, 32'h40);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    sb_q.push_back(mk(32'h700, 32'h0, exp_bypass_op1, 32'h40, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 8'h50));
    step();
    bus.in_valid = 1'b0; wb_we = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("wb_out_op1", bus.out_op1, exp_bypass_op1);
    step();
    bus.out_ready = 1'b0;
    step();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
